program_loader: RTL and testbench

//  Host-side end of the CPU programming interface. Buffers a DEPTH-word program from a valid/ready

---
 rtl/program_loader_pkg.sv | 25 ++
 rtl/program_loader_if.sv | 13 +
 rtl/program_loader_buffer.sv | 26 ++
 rtl/program_loader.sv | 167 ++++++++++++++++
 tb/tb_program_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states and SAP-1 opcodes.
package program_loader_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefDepth     = 16;

    typedef enum logic [2:0] {
        StFill    = 3'd0,
        StArm     = 3'd1,
        StProg    = 3'd2,
        StRestart = 3'd3,
        StRun     = 3'd4
    } state_e;

    // Opcode field is the upper nibble of a program word.
    localparam logic [3:0] OpHlt = 4'd0;
    localparam logic [3:0] OpLda = 4'd1;
    localparam logic [3:0] OpAdd = 4'd2;
    localparam logic [3:0] OpSub = 4'd3;
    localparam logic [3:0] OpOut = 4'd4;
    localparam logic [3:0] OpSta = 4'd5;
    localparam logic [3:0] OpLdi = 4'd6;
    localparam logic [3:0] OpJmp = 4'd7;

endpackage

// File: rtl/program_loader_if.sv
// Host-side valid/ready byte stream feeding the program loader.
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/program_loader_buffer.sv
// Program word store: one synchronous write port, one asynchronous read port, never cleared.
module program_loader_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: contents survive reset so a reload is the only way to change them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Buffers a program from the host, then serves it word by word to the CPU and restarts it.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned RESTART_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    program_loader_if.slave       host,
    input  logic                  load_req,
    input  logic                  ready,
    input  logic                  read_ui_in,
    input  logic                  done_load,
    input  logic                  HF,
    output logic                  programming,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  cpu_resetn,
    output logic [ADDR_WIDTH:0]   loaded_count,
    output logic                  halted,
    output logic                  proto_err
);

    localparam int unsigned CntWidth = (RESTART_CYCLES > 2) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [CntWidth-1:0]   CntLast   = CntWidth'(RESTART_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] PtrLast   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CountFull = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   loaded_q, loaded_d;
    logic                  halted_q, halted_d;
    logic                  err_q, err_d;
    logic                  seen_read_q, seen_read_d;
    logic                  wr_en;
    logic                  bad_strobe;

    // CPU fetch-stage indicator is informational only.
    logic unused_ready;
    assign unused_ready = ready;

    assign host.in_ready = (state_q == StFill);
    assign wr_en         = host.in_valid && (state_q == StFill);
    assign programming   = (state_q == StArm) || (state_q == StProg);
    assign cpu_resetn    = (state_q == StProg) || (state_q == StRun);
    assign loaded_count  = loaded_q;
    assign halted        = halted_q;
    assign proto_err     = err_q;

    // A done_load counts as unannounced unless a read_ui_in came since the previous done_load.
    assign bad_strobe = (read_ui_in && done_load)
                     || ((read_ui_in || done_load) && (state_q != StProg))
                     || ((state_q == StProg) && done_load && !seen_read_q);

    // Word server: rd_ptr is registered, so prog_data only moves on a done_load edge.
    program_loader_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (host.in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (prog_data)
    );

    // State register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFill;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            loaded_q    <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            seen_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            loaded_q    <= loaded_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
            seen_read_q <= seen_read_d;
        end
    end

    // Next-state logic: fill, arm, serve, restart, run.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        loaded_d    = loaded_q;
        halted_d    = halted_q;
        err_d       = err_q || bad_strobe;
        seen_read_d = seen_read_q;

        case (state_q)
            StFill: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PtrLast) begin
                        state_d = StArm;
                        cnt_d   = '0;
                    end
                end
            end
            StArm: begin
                if (cnt_q == CntLast) begin
                    state_d     = StProg;
                    cnt_d       = '0;
                    seen_read_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StProg: begin
                if (read_ui_in) begin
                    seen_read_d = 1'b1;
                end
                if (done_load) begin
                    seen_read_d = 1'b0;
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    if (loaded_q != CountFull) begin
                        loaded_d = loaded_q + 1'b1;
                    end
                    if (rd_ptr_q == PtrLast) begin
                        state_d = StRestart;
                        cnt_d   = '0;
                    end
                end
            end
            StRestart: begin
                if (cnt_q == CntLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (HF) begin
                    halted_d = 1'b1;
                end
                if (load_req) begin
                    state_d  = StFill;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    loaded_d = '0;
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = StFill;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: host words queued on acceptance, checked when the CPU reads.
module tb_program_loader;
    import program_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req, ready, read_ui_in, done_load, HF;
    logic       programming, cpu_resetn, halted, proto_err;
    logic [7:0] prog_data;
    logic [4:0] loaded_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ram[16];

    program_loader_if #(.DATA_WIDTH(8)) host_if ();

    program_loader #(
        .DATA_WIDTH     (8),
        .DEPTH          (16),
        .ADDR_WIDTH     (4),
        .RESTART_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (host_if),
        .load_req     (load_req),
        .ready        (ready),
        .read_ui_in   (read_ui_in),
        .done_load    (done_load),
        .HF           (HF),
        .programming  (programming),
        .prog_data    (prog_data),
        .cpu_resetn   (cpu_resetn),
        .loaded_count (loaded_count),
        .halted       (halted),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every CPU read in programming mode must see the next queued host word.
    always @(negedge clk) begin
        if (read_ui_in && programming && cpu_resetn) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: read of %0h with nothing queued", prog_data);
            end else begin
                check("prog_data", 32'(prog_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Offer one word for one cycle; it is queued only if the loader is ready this cycle.
    task automatic offer(input logic [7:0] w, output bit acc);
        host_if.in_valid = 1'b1;
        host_if.in_data  = w;
        acc = host_if.in_ready;
        if (acc) exp_q.push_back(w);
        step();
        host_if.in_valid = 1'b0;
    endtask

    task automatic wait_prog();
        for (int i = 0; i < 50 && !(programming && cpu_resetn); i++) step();
        check("reach_prog", 32'(programming && cpu_resetn), 32'd1);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 50 && !(cpu_resetn && !programming); i++) step();
        check("reach_run", 32'(cpu_resetn && !programming), 32'd1);
    endtask

    // CPU model: read pulse then done_load pulse per word, capturing into a RAM model.
    task automatic cpu_load(input int first, input int n);
        logic [7:0] cap;
        for (int k = 0; k < n; k++) begin
            read_ui_in = 1'b1;
            cap = prog_data;
            step();
            read_ui_in = 1'b0;
            done_load  = 1'b1;
            step();
            done_load  = 1'b0;
            ram[(first + k) % 16] = cap;
        end
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int n_acc;
        reset = 1'b1; load_req = 0; ready = 0; read_ui_in = 0; done_load = 0; HF = 0;
        host_if.in_valid = 1'b0;
        host_if.in_data  = 8'h00;

        // 1: reset values
        #1;
        check("rst_programming", 32'(programming), 32'd0);
        check("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
        check("rst_in_ready", 32'(host_if.in_ready), 32'd1);
        check("rst_loaded_count", 32'(loaded_count), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        step();
        reset = 1'b0;
        step();

        // 2: back-to-back stream 0x40..0x4F
        for (int i = 0; i < 16; i++) begin
            check("fill_in_ready", 32'(host_if.in_ready), 32'd1);
            offer(8'(8'h40 + i), acc);
        end
        check("arm1_in_ready", 32'(host_if.in_ready), 32'd0);
        check("arm1_programming", 32'(programming), 32'd1);
        check("arm1_cpu_resetn", 32'(cpu_resetn), 32'd0);
        step();
        check("arm2_cpu_resetn", 32'(cpu_resetn), 32'd0);
        step();
        check("prog_cpu_resetn", 32'(cpu_resetn), 32'd1);
        check("prog_programming", 32'(programming), 32'd1);
        cpu_load(0, 16);
        check("restart1_programming", 32'(programming), 32'd0);
        check("restart1_cpu_resetn", 32'(cpu_resetn), 32'd0);
        check("t2_loaded_count", 32'(loaded_count), 32'd16);
        step();
        check("restart2_cpu_resetn", 32'(cpu_resetn), 32'd0);
        step();
        check("run_cpu_resetn", 32'(cpu_resetn), 32'd1);
        check("run_in_ready", 32'(host_if.in_ready), 32'd0);
        check("t2_proto_err", 32'(proto_err), 32'd0);
        for (int i = 0; i < 16; i++) check("t2_ram", 32'(ram[i]), 32'(8'h40 + i));

        // 3: sparse host, 20 words offered, only 16 taken
        pulse_load_req();
        check("reload_in_ready", 32'(host_if.in_ready), 32'd1);
        n_acc = 0;
        for (int w = 0; w < 20; w++) begin
            offer(8'(8'h80 + w), acc);
            if (acc) n_acc++;
            if (w >= 16) check("t3_extra_not_acked", 32'(acc), 32'd0);
            step();
            step();
        end
        check("t3_accepted", 32'(n_acc), 32'd16);
        wait_prog();
        cpu_load(0, 16);
        wait_run();
        check("t3_loaded_count", 32'(loaded_count), 32'd16);
        for (int i = 0; i < 16; i++) check("t3_ram", 32'(ram[i]), 32'(8'h80 + i));

        // 4: unannounced done_load sets sticky proto_err, pointer still advances
        pulse_load_req();
        for (int i = 0; i < 16; i++) offer(8'(8'h10 + i), acc);
        wait_prog();
        check("t4_proto_err_before", 32'(proto_err), 32'd0);
        done_load = 1'b1;
        step();
        done_load = 1'b0;
        void'(exp_q.pop_front());
        check("t4_proto_err_set", 32'(proto_err), 32'd1);
        check("t4_loaded_count", 32'(loaded_count), 32'd1);
        pulse_load_req();
        check("t4_load_req_ignored", 32'(programming), 32'd1);
        cpu_load(1, 4);
        check("t4_proto_err_sticky", 32'(proto_err), 32'd1);
        check("t4_loaded_count5", 32'(loaded_count), 32'd5);

        // 5: reset mid-programming
        reset = 1'b1;
        #1;
        check("t5_programming", 32'(programming), 32'd0);
        check("t5_cpu_resetn", 32'(cpu_resetn), 32'd0);
        check("t5_loaded_count", 32'(loaded_count), 32'd0);
        check("t5_proto_err", 32'(proto_err), 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        check("t5_in_ready", 32'(host_if.in_ready), 32'd1);

        // 6: program ending in HLT, halt flag, stray read in RUN, then reload
        for (int i = 0; i < 16; i++) offer((i == 15) ? {OpHlt, 4'h0} : {OpLdi, 4'(i)}, acc);
        wait_prog();
        cpu_load(0, 16);
        wait_run();
        check("t6_ram3", 32'(ram[3]), 32'h63);
        check("t6_ram15_hlt", 32'(ram[15]), 32'h00);
        check("t6_halted_before", 32'(halted), 32'd0);
        HF = 1'b1;
        step();
        HF = 1'b0;
        check("t6_halted", 32'(halted), 32'd1);
        step();
        check("t6_halted_sticky", 32'(halted), 32'd1);
        read_ui_in = 1'b1;
        step();
        read_ui_in = 1'b0;
        check("t6_proto_err_run_read", 32'(proto_err), 32'd1);
        pulse_load_req();
        check("t6_in_ready", 32'(host_if.in_ready), 32'd1);
        check("t6_halted_clr", 32'(halted), 32'd0);
        check("t6_proto_err_clr", 32'(proto_err), 32'd0);
        check("t6_cpu_resetn", 32'(cpu_resetn), 32'd0);
        check("t6_programming", 32'(programming), 32'd0);
        check("t6_loaded_count", 32'(loaded_count), 32'd0);

        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
